// File: rtl/mask_frame_reader.sv
// Display-side reader for the double-banked 1-bit mask frame buffer: window/upscale addressing,
// BRAM latency alignment and bank swapping. Define MASK_FRAME_READER_MIRROR_EN for a horizontally mirrored view.
module mask_frame_reader #(
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 240,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int SWAP_LINE  = 480,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 17
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic              frame_done_in,
  output logic              swap_ack_out,
  output logic              wr_bank_out,
  output logic [ADDR_W:0]   rd_addr_out,
  input  logic              rd_data_in,
  output logic              pixel_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              state_out
);

  localparam int WIN_W = SRC_W << SCALE_LOG2;
  localparam int WIN_H = SRC_H << SCALE_LOG2;
  localparam int DW    = 25;

  typedef enum logic {SHOW = 1'b0, PENDING = 1'b1} bank_state_t;

  bank_state_t       state_q, state_d;
  logic              swap_now, swap_take;
  logic              disp_bank;

  logic [11:0]       hrel;
  logic [10:0]       vrel;
  logic              in_win;
  logic [10:0]       col_raw, col;
  logic [ADDR_W-1:0] row_base_q, row_base, addr_q, addr_next;
  logic [9:0]        last_v;
  logic              new_line, blk_start;

  logic [DW-1:0]     stage_in;
  logic [DW-1:0]     dly [RD_LAT+1];

  // Offsets wrap negative (top bit set) when the beam is left of / above the window.
  assign hrel   = {1'b0, hcount_in} - 12'(X0);
  assign vrel   = {1'b0, vcount_in} - 11'(Y0);
  assign in_win = !hrel[11] && (hrel < 12'(WIN_W)) && !vrel[10] && (vrel < 11'(WIN_H));

  assign col_raw = hrel[10:0] >> SCALE_LOG2;
`ifdef MASK_FRAME_READER_MIRROR_EN
  assign col = 11'(SRC_W - 1) - col_raw;
`else
  assign col = col_raw;
`endif

  // Row base advances by one source row on the first display line of each upscaled block.
  assign new_line  = (vcount_in != last_v);
  assign blk_start = (vrel & 11'((1 << SCALE_LOG2) - 1)) == 11'd0;

  always_comb begin
    row_base = row_base_q;
    if (vrel == 11'd0)
      row_base = '0;
    else if (new_line && blk_start)
      row_base = row_base_q + ADDR_W'(SRC_W);
  end

  assign addr_next = row_base + ADDR_W'(col);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      row_base_q <= '0;
      last_v     <= '0;
      addr_q     <= '0;
    end else begin
      row_base_q <= row_base;
      last_v     <= vcount_in;
      if (in_win)
        addr_q <= addr_next;
    end
  end

  assign rd_addr_out = {disp_bank, addr_q};

  // Timing and window flag travel together so pixel_out lines up with the BRAM data.
  assign stage_in = {in_win, blank_in, vsync_in, hsync_in, vcount_in, hcount_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i <= RD_LAT; i++)
        dly[i] <= '0;
    end else begin
      dly[0] <= stage_in;
      for (int i = 1; i <= RD_LAT; i++)
        dly[i] <= dly[i-1];
    end
  end

  assign hcount_out = dly[RD_LAT][10:0];
  assign vcount_out = dly[RD_LAT][20:11];
  assign hsync_out  = dly[RD_LAT][21];
  assign vsync_out  = dly[RD_LAT][22];
  assign blank_out  = dly[RD_LAT][23];
  assign pixel_out  = rd_data_in & dly[RD_LAT][24];

  assign swap_now = (vcount_in == 10'(SWAP_LINE)) && (hcount_in == 11'd0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state_q <= SHOW;
    else
      state_q <= state_d;
  end

  // A done pulse arriving while a swap is pending is dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW:    if (frame_done_in) state_d = PENDING;
      PENDING: if (swap_now)      state_d = SHOW;
      default: state_d = SHOW;
    endcase
  end

  always_comb begin
    swap_take = (state_q == PENDING) && swap_now;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      disp_bank    <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      disp_bank    <= disp_bank ^ swap_take;
      swap_ack_out <= swap_take;
    end
  end

  assign wr_bank_out = ~disp_bank;
  assign state_out   = state_q;

endmodule

// File: tb/tb_mask_frame_reader.sv
// Directed bench for mask_frame_reader: reset, addressing, latency alignment and bank swapping.
// Follows MASK_FRAME_READER_MIRROR_EN for the expected column mapping.
module tb_mask_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0, frame_done_in = 1'b0;
  logic        swap_ack_out, wr_bank_out;
  logic [17:0] rd_addr_out;
  logic        rd_data_in;
  logic        pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, blank_out, state_out;

  int n_cmp = 0;
  int n_fail = 0;
  int ack_count = 0;
  int ack_base = 0;

  localparam int BANK1 = 131072;

  always #5 clk = ~clk;

  mask_frame_reader dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .blank_in      (blank_in),
    .frame_done_in (frame_done_in),
    .swap_ack_out  (swap_ack_out),
    .wr_bank_out   (wr_bank_out),
    .rd_addr_out   (rd_addr_out),
    .rd_data_in    (rd_data_in),
    .pixel_out     (pixel_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .blank_out     (blank_out),
    .state_out     (state_out)
  );

  // Two-cycle BRAM model whose stored bit is the low address bit.
  logic [17:0] bram_p0 = '0, bram_p1 = '0;
  always @(posedge clk) begin
    bram_p0 <= rd_addr_out;
    bram_p1 <= bram_p0;
  end
  assign rd_data_in = bram_p1[0];

  always @(negedge clk) if (swap_ack_out === 1'b1) ack_count++;

  function automatic int mc(input int c);
`ifdef MASK_FRAME_READER_MIRROR_EN
    return 319 - c;
`else
    return c;
`endif
  endfunction

  function automatic int ea(input int row, input int c);
    return row * 320 + mc(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic done);
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    blank_in      = (h >= 640) || (v >= 480);
    hsync_in      = (h >= 656) && (h < 752);
    vsync_in      = (v >= 490) && (v < 492);
    frame_done_in = done;
    @(posedge clk);
    #1;
  endtask

  task automatic run_lines(input int v_from, input int v_to);
    for (int v = v_from; v <= v_to; v++) drive(700, v, 1'b0);
  endtask

  initial begin
    // Reset held while a line is being scanned.
    drive(100, 5, 1'b0);
    drive(101, 5, 1'b0);
    check("rst_rd_addr", rd_addr_out, 0);
    check("rst_wr_bank", wr_bank_out, 1);
    check("rst_swap_ack", swap_ack_out, 0);
    check("rst_pixel", pixel_out, 0);
    check("rst_hcount", hcount_out, 0);
    check("rst_state", state_out, 0);

    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 1'b0);
    check("addr_0_0", rd_addr_out, ea(0, 0));
    drive(2, 0, 1'b0);
    check("addr_2_0", rd_addr_out, ea(0, 1));
    drive(1, 1, 1'b0);
    check("addr_1_1", rd_addr_out, ea(0, 0));
    check("lat_first_vcount", vcount_out, 0);
    check("lat_first_pixel", pixel_out, ea(0, 0) & 1);
    drive(0, 2, 1'b0);
    check("addr_0_2", rd_addr_out, ea(1, 0));
    check("lat_hcount_2", hcount_out, 2);
    check("lat_pixel_2_0", pixel_out, ea(0, 1) & 1);
    drive(3, 2, 1'b0);
    check("lat_hcount_1", hcount_out, 1);
    check("lat_vcount_1", vcount_out, 1);

    run_lines(3, 99);
    drive(10, 100, 1'b1);
    check("addr_10_100", rd_addr_out, ea(50, 5));
    check("pending_after_done", state_out, 1);
    run_lines(101, 199);
    drive(700, 200, 1'b1);
    check("pending_second_done", state_out, 1);
    run_lines(201, 478);
    ack_base = ack_count;

    drive(639, 479, 1'b0);
    check("addr_639_479", rd_addr_out, ea(239, 319));
    drive(640, 479, 1'b0);
    check("addr_hold_640", rd_addr_out, ea(239, 319));
    drive(641, 479, 1'b0);
    check("lat_hcount_639", hcount_out, 639);
    check("lat_pixel_639", pixel_out, ea(239, 319) & 1);
    check("lat_blank_639", blank_out, 0);
    drive(642, 479, 1'b0);
    check("lat_hcount_640", hcount_out, 640);
    check("pixel_off_window", pixel_out, 0);
    check("lat_blank_640", blank_out, 1);

    drive(0, 480, 1'b0);
    check("swap_ack_pulse", swap_ack_out, 1);
    check("swap_wr_bank", wr_bank_out, 0);
    check("swap_rd_addr_bank", rd_addr_out, BANK1 + ea(239, 319));
    check("swap_state_show", state_out, 0);
    drive(1, 480, 1'b0);
    check("swap_ack_drop", swap_ack_out, 0);
    run_lines(481, 524);
    check("one_ack_two_dones", ack_count - ack_base, 1);

    drive(2, 0, 1'b0);
    check("addr_bank1_2_0", rd_addr_out, BANK1 + ea(0, 1));
    run_lines(1, 4);
    drive(10, 5, 1'b0);
    drive(10, 5, 1'b0);
    drive(10, 5, 1'b0);

    // Reset dropped mid-cycle with a full pipeline.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_hcount", hcount_out, 0);
    check("midrst_vcount", vcount_out, 0);
    check("midrst_rd_addr", rd_addr_out, 0);
    check("midrst_wr_bank", wr_bank_out, 1);
    check("midrst_pixel", pixel_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(6, 0, 1'b0);
    check("resume_addr", rd_addr_out, ea(0, 3));
    drive(1, 0, 1'b1);
    drive(2, 0, 1'b0);
    check("resume_hcount", hcount_out, 6);
    check("resume_pixel", pixel_out, ea(0, 3) & 1);
    check("resume_pending", state_out, 1);

    run_lines(1, 479);
    ack_base = ack_count;
    drive(0, 480, 1'b1);
    check("coinc_ack", swap_ack_out, 1);
    check("coinc_wr_bank", wr_bank_out, 0);
    check("coinc_state", state_out, 0);
    drive(1, 480, 1'b0);
    check("coinc_ack_drop", swap_ack_out, 0);
    run_lines(481, 524);
    run_lines(0, 479);
    drive(0, 480, 1'b0);
    drive(1, 480, 1'b0);
    check("coinc_single_ack", ack_count - ack_base, 1);
    check("coinc_bank_stays", wr_bank_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
